// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV64I datapath: one FETCH->...->FETCH loop per instruction,
// driving all datapath strobes and a shared single-port memory through a req/ready handshake.
module multicycle_control_unit (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_addr_sel,
  output logic        WE_MEM,
  output logic        WE_RF,
  output logic [1:0]  RF_din_sel,
  output logic        ULA_din2_sel,
  output logic        load_pc,
  output logic        load_ir,
  output logic        pc_next_sel,
  output logic        pc_adder_sel,
  output logic        dp_reset,
  output logic        halted,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC_ALU = 3'd2,
    MEM      = 3'd3,
    BRANCH   = 3'd4,
    JUMP     = 3'd5,
    AUIPC    = 3'd6,
    HALT     = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    WE_MEM       = 1'b0;
    WE_RF        = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    halted       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R, OP_RW, OP_I, OP_IW, OP_LUI: state_d = EXEC_ALU;
          OP_LOAD, OP_STORE:                state_d = MEM;
          OP_BR:                            state_d = BRANCH;
          OP_JAL, OP_JALR:                  state_d = JUMP;
          OP_AUIPC:                         state_d = AUIPC;
          default:                          state_d = HALT;
        endcase
      end
      EXEC_ALU: begin
        WE_RF        = 1'b1;
        RF_din_sel   = 2'b01;
        ULA_din2_sel = !(opcode == OP_R || opcode == OP_RW);
        load_pc      = 1'b1;
        state_d      = FETCH;
      end
      MEM: begin
        // Request, address and write enable stay fixed for the whole wait.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        ULA_din2_sel = 1'b1;
        WE_MEM       = (opcode == OP_STORE);
        if (mem_ready) begin
          load_pc = 1'b1;
          WE_RF   = (opcode == OP_LOAD);
          state_d = FETCH;
        end
      end
      BRANCH: begin
        pc_next_sel = 1'b1;
        load_pc     = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        WE_RF        = 1'b1;
        RF_din_sel   = 2'b10;
        ULA_din2_sel = 1'b1;
        pc_next_sel  = 1'b1;
        pc_adder_sel = (opcode == OP_JALR);
        load_pc      = 1'b1;
        state_d      = FETCH;
      end
      AUIPC: begin
        WE_RF      = 1'b1;
        RF_din_sel = 2'b11;
        load_pc    = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  assign instret_d = load_pc ? instret_q + 32'd1 : instret_q;
  assign instret   = instret_q;
  assign state     = state_q;
  assign dp_reset  = !reset_n;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class through its states
// and compares the packed strobe vector, state and instret against hand-computed values.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = 7'b0110011;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_addr_sel, WE_MEM, WE_RF, ULA_din2_sel, load_pc, load_ir;
  logic        pc_next_sel, pc_adder_sel, dp_reset, halted;
  logic [1:0]  RF_din_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 32'd0;

  // [11]mem_req [10]mem_addr_sel [9]WE_MEM [8]WE_RF [7:6]RF_din_sel [5]ULA_din2_sel
  // [4]load_pc [3]load_ir [2]pc_next_sel [1]pc_adder_sel [0]halted
  wire [11:0] strobes = {mem_req, mem_addr_sel, WE_MEM, WE_RF, RF_din_sel, ULA_din2_sel,
                         load_pc, load_ir, pc_next_sel, pc_adder_sel, halted};

  multicycle_control_unit dut (
    .CLK(CLK), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .WE_MEM(WE_MEM), .WE_RF(WE_RF),
    .RF_din_sel(RF_din_sel), .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc),
    .load_ir(load_ir), .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
    .dp_reset(dp_reset), .halted(halted), .instret(instret), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    @(negedge CLK); #1;
    total++;
    if ({state, dp_reset, instret} !== {3'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL reset_state got state=%0d dp_reset=%0b instret=%0h", state, dp_reset, instret);
    end
    total++;
    if (strobes !== 12'h800) begin
      bad++; $display("FAIL reset_strobes got=%03h exp=800", strobes);
    end
    @(negedge CLK); reset_n = 1'b1; #1;
    total++;
    if ({state, dp_reset} !== {3'd0, 1'b0}) begin
      bad++; $display("FAIL reset_release got state=%0d dp_reset=%0b exp state=0 dp_reset=0", state, dp_reset);
    end
    exp_instret = 32'd0;
  endtask

  // Runs a 3-cycle instruction (FETCH, DECODE, exec) with zero-wait memory.
  task automatic test_three_cycle(input string name, input logic [6:0] op, input logic [2:0] exec_state,
                                  input logic [11:0] exec_strobes);
    opcode = op; mem_ready = 1'b1; #1;
    total++;
    if ({state, strobes} !== {3'd0, 12'h808}) begin
      bad++; $display("FAIL %s_fetch got state=%0d strobes=%03h exp state=0 strobes=808", name, state, strobes);
    end
    @(negedge CLK); #1;
    total++;
    if ({state, strobes} !== {3'd1, 12'h000}) begin
      bad++; $display("FAIL %s_decode got state=%0d strobes=%03h exp state=1 strobes=000", name, state, strobes);
    end
    @(negedge CLK); #1;
    total++;
    if ({state, strobes} !== {exec_state, exec_strobes}) begin
      bad++; $display("FAIL %s_exec got state=%0d strobes=%03h exp state=%0d strobes=%03h",
                      name, state, strobes, exec_state, exec_strobes);
    end
    @(negedge CLK); #1;
    exp_instret = exp_instret + 32'd1;
    total++;
    if ({state, instret} !== {3'd0, exp_instret}) begin
      bad++; $display("FAIL %s_retire got state=%0d instret=%0h exp state=0 instret=%0h", name, state, instret, exp_instret);
    end
  endtask

  task automatic test_alu();
    test_three_cycle("add", 7'b0110011, 3'd2, 12'h150);
    test_three_cycle("addi", 7'b0010011, 3'd2, 12'h170);
    test_three_cycle("lui", 7'b0110111, 3'd2, 12'h170);
  endtask

  task automatic test_load_wait();
    opcode = 7'b0000011; mem_ready = 1'b1; #1;
    @(negedge CLK); mem_ready = 1'b0; #1;
    total++;
    if ({state, strobes} !== {3'd1, 12'h000}) begin
      bad++; $display("FAIL load_decode got state=%0d strobes=%03h exp state=1 strobes=000", state, strobes);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #1;
      total++;
      if ({state, strobes} !== {3'd3, 12'hC20}) begin
        bad++; $display("FAIL load_wait%0d got state=%0d strobes=%03h exp state=3 strobes=C20", c, state, strobes);
      end
    end
    @(negedge CLK); mem_ready = 1'b1; #1;
    total++;
    if ({state, strobes} !== {3'd3, 12'hD30}) begin
      bad++; $display("FAIL load_done got state=%0d strobes=%03h exp state=3 strobes=D30", state, strobes);
    end
    @(negedge CLK); #1;
    exp_instret = exp_instret + 32'd1;
    total++;
    if ({state, instret} !== {3'd0, exp_instret}) begin
      bad++; $display("FAIL load_retire got state=%0d instret=%0h exp state=0 instret=%0h", state, instret, exp_instret);
    end
  endtask

  task automatic test_store();
    logic saw_we_rf;
    saw_we_rf = 1'b0;
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    @(negedge CLK); mem_ready = 1'b0; #1;
    saw_we_rf = saw_we_rf | WE_RF;
    @(negedge CLK); #1;
    saw_we_rf = saw_we_rf | WE_RF;
    total++;
    if ({state, strobes} !== {3'd3, 12'hE20}) begin
      bad++; $display("FAIL store_wait got state=%0d strobes=%03h exp state=3 strobes=E20", state, strobes);
    end
    @(negedge CLK); mem_ready = 1'b1; #1;
    saw_we_rf = saw_we_rf | WE_RF;
    total++;
    if ({state, strobes} !== {3'd3, 12'hE30}) begin
      bad++; $display("FAIL store_done got state=%0d strobes=%03h exp state=3 strobes=E30", state, strobes);
    end
    @(negedge CLK); #1;
    exp_instret = exp_instret + 32'd1;
    total++;
    if ({saw_we_rf, state, instret} !== {1'b0, 3'd0, exp_instret}) begin
      bad++; $display("FAIL store_retire got we_rf_seen=%0b state=%0d instret=%0h exp 0/0/%0h",
                      saw_we_rf, state, instret, exp_instret);
    end
  endtask

  task automatic test_jump();
    test_three_cycle("jalr", 7'b1100111, 3'd5, 12'h1B6);
    test_three_cycle("jal", 7'b1101111, 3'd5, 12'h1B4);
  endtask

  task automatic test_back_to_back();
    test_three_cycle("branch", 7'b1100011, 3'd4, 12'h014);
    test_three_cycle("auipc", 7'b0010111, 3'd6, 12'h1D0);
    test_three_cycle("addw", 7'b0111011, 3'd2, 12'h150);
  endtask

  task automatic test_halt();
    logic saw_req;
    saw_req = 1'b0;
    opcode = 7'b0000000; mem_ready = 1'b1;
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    total++;
    if ({state, strobes} !== {3'd7, 12'h001}) begin
      bad++; $display("FAIL halt_enter got state=%0d strobes=%03h exp state=7 strobes=001", state, strobes);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK); #1;
      saw_req = saw_req | mem_req | (state !== 3'd7);
    end
    total++;
    if ({saw_req, instret} !== {1'b0, exp_instret}) begin
      bad++; $display("FAIL halt_hold got req_or_exit=%0b instret=%0h exp 0/%0h", saw_req, instret, exp_instret);
    end
    reset_n = 1'b0; #1;
    total++;
    if ({state, halted, dp_reset, instret} !== {3'd0, 1'b0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL halt_reset got state=%0d halted=%0b dp_reset=%0b instret=%0h exp 0/0/1/0",
                      state, halted, dp_reset, instret);
    end
    @(negedge CLK); reset_n = 1'b1;
    exp_instret = 32'd0;
  endtask

  task automatic test_wrap();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    total++;
    if (instret !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_preload got instret=%0h exp=ffffffff", instret);
    end
    exp_instret = 32'hFFFF_FFFF;
    test_three_cycle("wrap", 7'b0110011, 3'd2, 12'h150);
  endtask

  task automatic test_reset_mid_mem();
    test_three_cycle("pre", 7'b0010011, 3'd2, 12'h170);
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    @(negedge CLK); mem_ready = 1'b0;
    @(negedge CLK); #1;
    total++;
    if ({state, strobes} !== {3'd3, 12'hE20}) begin
      bad++; $display("FAIL midmem_wait got state=%0d strobes=%03h exp state=3 strobes=E20", state, strobes);
    end
    reset_n = 1'b0; #1;
    total++;
    if ({state, strobes, instret, dp_reset} !== {3'd0, 12'h800, 32'd0, 1'b1}) begin
      bad++; $display("FAIL midmem_reset got state=%0d strobes=%03h instret=%0h dp_reset=%0b exp 0/800/0/1",
                      state, strobes, instret, dp_reset);
    end
    @(negedge CLK); reset_n = 1'b1;
    exp_instret = 32'd0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_jump();
    test_back_to_back();
    test_halt();
    test_wrap();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got time=%0t exp finish before 100000", $time);
    $fatal(1);
  end

endmodule
